// File: rtl/ds_strobe_sched_pkg.sv
// Shared types and constants for the FSK demodulator decimation scheduler.
// Holds the state encoding, reset defaults, gain and saturation limits.
package fsk_ds_pkg;

    localparam int DATA_W     = 16;
    localparam int PHASE_W    = 6;
    localparam int DEF_OFFSET = 4;
    localparam int DEF_PERIOD = 32;
    localparam int GAIN_SHIFT = 3;

    localparam logic signed [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MAX_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Returns {adv_pend, ret_pend}; opposite requests cancel and repeats are dropped.
    function automatic logic [1:0] apply_nudge(input logic adv_pend,
                                               input logic ret_pend,
                                               input logic adv_req,
                                               input logic ret_req);
        logic [1:0] result;
        result = {adv_pend, ret_pend};
        if (adv_req && !ret_req) begin
            result = ret_pend ? 2'b00 : 2'b10;
        end else if (ret_req && !adv_req) begin
            result = adv_pend ? 2'b00 : 2'b01;
        end
        return result;
    endfunction

endpackage

// File: rtl/ds_strobe_sched_if.sv
// Sample, configuration and nudge bundle between the timing loop and the scheduler.
// The master drives samples and requests; the slave (scheduler) returns captures.
interface ds_strobe_sched_if #(
    parameter int DW    = 16,
    parameter int CNT_W = 6
);
    logic                 enable;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CNT_W-1:0]     cfg_offset;
    logic [CNT_W-1:0]     cfg_period;
    logic                 adv_req;
    logic                 ret_req;
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] y;
    logic                 y_valid;
    logic                 busy;
    logic [7:0]           samp_cnt;

    modport master (
        output enable, cfg_valid, cfg_offset, cfg_period, adv_req, ret_req, x,
        input  cfg_ready, y, y_valid, busy, samp_cnt
    );

    modport slave (
        input  enable, cfg_valid, cfg_offset, cfg_period, adv_req, ret_req, x,
        output cfg_ready, y, y_valid, busy, samp_cnt
    );
endinterface

// File: rtl/ds_strobe_sched_sat_shift.sv
// Combinational arithmetic left shift that clamps to the signed range
// instead of wrapping when the gained sample no longer fits in DW bits.
module ds_sat_shift #(
    parameter int DW         = fsk_ds_pkg::DATA_W,
    parameter int GAIN_SHIFT = fsk_ds_pkg::GAIN_SHIFT
) (
    input  logic signed [DW-1:0] i_x,
    output logic signed [DW-1:0] o_y
);
    import fsk_ds_pkg::*;

    logic signed [DW+GAIN_SHIFT-1:0] w_wide;
    logic        [GAIN_SHIFT:0]      w_top;

    assign w_wide = {{GAIN_SHIFT{i_x[DW-1]}}, i_x} <<< GAIN_SHIFT;
    assign w_top  = w_wide[DW+GAIN_SHIFT-1:DW-1];

    // The result fits only when the discarded bits all match the new sign bit.
    always_comb begin
        o_y = w_wide[DW-1:0];
        if (!(&w_top) && (|w_top)) begin
            o_y = w_top[GAIN_SHIFT] ? MAX_NEG : MAX_POS;
        end
    end

endmodule

// File: rtl/ds_strobe_sched.sv
// Decimation strobe scheduler: waits out a phase offset, then captures one
// gained sample per symbol period, honouring one-clock nudges from timing recovery.
module ds_strobe_sched
    import fsk_ds_pkg::*;
#(
    parameter int DW    = DATA_W,
    parameter int CNT_W = PHASE_W
) (
    input logic             i_clk,
    input logic             i_rst_n,
    ds_strobe_sched_if.slave bus
);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     r_off;
    logic [CNT_W-1:0]     r_per;
    logic                 r_adv_pend;
    logic                 r_ret_pend;
    logic signed [DW-1:0] r_y;
    logic                 r_y_valid;
    logic                 r_busy;
    logic                 r_cfg_ready;
    logic [7:0]           r_samp_cnt;

    logic [CNT_W-1:0]     w_term;
    logic signed [DW-1:0] w_scaled;

    ds_sat_shift #(
        .DW         (DW),
        .GAIN_SHIFT (GAIN_SHIFT)
    ) u_sat (
        .i_x (bus.x),
        .o_y (w_scaled)
    );

    always_comb begin
        w_term = r_per - CNT_W'(1);
        if (r_adv_pend) begin
            w_term = r_per - CNT_W'(2);
        end else if (r_ret_pend) begin
            w_term = r_per;
        end
    end

    // A nudge landing after the shortened terminal has passed still ends the
    // period at the next edge, hence >= rather than == in RUN.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_off       <= CNT_W'(DEF_OFFSET);
            r_per       <= CNT_W'(DEF_PERIOD);
            r_adv_pend  <= 1'b0;
            r_ret_pend  <= 1'b0;
            r_y         <= '0;
            r_y_valid   <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_samp_cnt  <= '0;
        end else begin
            r_y_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cfg_valid) begin
                        r_off <= bus.cfg_offset;
                        r_per <= (bus.cfg_period < CNT_W'(2)) ? CNT_W'(2) : bus.cfg_period;
                    end
                    if (bus.enable) begin
                        r_state     <= ST_ALIGN;
                        r_cnt       <= '0;
                        r_adv_pend  <= 1'b0;
                        r_ret_pend  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cfg_ready <= 1'b0;
                    end
                end
                ST_ALIGN: begin
                    if (!bus.enable) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        r_busy      <= 1'b0;
                        r_cfg_ready <= 1'b1;
                    end else begin
                        {r_adv_pend, r_ret_pend} <= apply_nudge(r_adv_pend, r_ret_pend,
                                                                bus.adv_req, bus.ret_req);
                        if (r_cnt == r_off) begin
                            r_y        <= w_scaled;
                            r_y_valid  <= 1'b1;
                            r_samp_cnt <= r_samp_cnt + 8'd1;
                            r_cnt      <= '0;
                            r_state    <= ST_RUN;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (!bus.enable) begin
                        r_state     <= ST_IDLE;
                        r_cnt       <= '0;
                        r_busy      <= 1'b0;
                        r_cfg_ready <= 1'b1;
                    end else if (r_cnt >= w_term) begin
                        r_y        <= w_scaled;
                        r_y_valid  <= 1'b1;
                        r_samp_cnt <= r_samp_cnt + 8'd1;
                        r_cnt      <= '0;
                        {r_adv_pend, r_ret_pend} <= apply_nudge(1'b0, 1'b0,
                                                                bus.adv_req, bus.ret_req);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        {r_adv_pend, r_ret_pend} <= apply_nudge(r_adv_pend, r_ret_pend,
                                                                bus.adv_req, bus.ret_req);
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.y         = r_y;
    assign bus.y_valid   = r_y_valid;
    assign bus.busy      = r_busy;
    assign bus.cfg_ready = r_cfg_ready;
    assign bus.samp_cnt  = r_samp_cnt;

endmodule

// File: tb/tb_ds_strobe_sched.sv
// Directed bench for ds_strobe_sched: a capture-timing model checked every cycle,
// plus hand-computed capture spacings and sample values.
module tb_ds_strobe_sched;

    logic clk;
    logic rst_n;

    ds_strobe_sched_if #(.DW(16), .CNT_W(6)) bus ();

    ds_strobe_sched #(.DW(16), .CNT_W(6)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int lastEdge = 0;

    int mMode;
    int mOff;
    int mPer;
    int mElapsed;
    int mNudge;
    int mY;
    int mCount;
    bit mValid;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int edgeNow();
        return int'($time / 10) - 1;
    endfunction

    function automatic int satScale(input int v);
        int s;
        s = v * 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    // Net period adjustment: -1 shortens, +1 lengthens; opposite requests cancel.
    function automatic int nudged(input int n, input int d);
        if (d == 0) return n;
        if (n == 0) return d;
        if (n == -d) return 0;
        return n;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit cv, input int off, input int per);
        bus.enable     = en;
        bus.cfg_valid  = cv;
        bus.cfg_offset = 6'(off);
        bus.cfg_period = 6'(per);
    endtask

    // Model: counts edges since the last capture and fires when the adjusted period elapses.
    always @(posedge clk or negedge rst_n) begin : model
        int nMode, nOff, nPer, nElapsed, nNudge, nY, nCount, d;
        bit nValid;
        if (!rst_n) begin
            mMode    <= 0;
            mOff     <= 4;
            mPer     <= 32;
            mElapsed <= 0;
            mNudge   <= 0;
            mY       <= 0;
            mCount   <= 0;
            mValid   <= 1'b0;
        end else begin
            nMode = mMode; nOff = mOff; nPer = mPer; nElapsed = mElapsed;
            nNudge = mNudge; nY = mY; nCount = mCount; nValid = 1'b0;
            d = 0;
            if (bus.ret_req && !bus.adv_req) d = 1;
            if (bus.adv_req && !bus.ret_req) d = -1;
            case (mMode)
                0: begin
                    if (bus.cfg_valid) begin
                        nOff = int'(bus.cfg_offset);
                        nPer = (int'(bus.cfg_period) < 2) ? 2 : int'(bus.cfg_period);
                    end
                    if (bus.enable) begin
                        nMode = 1; nElapsed = 0; nNudge = 0;
                    end
                end
                1: begin
                    if (!bus.enable) nMode = 0;
                    else begin
                        nNudge = nudged(mNudge, d);
                        nElapsed = mElapsed + 1;
                        if (nElapsed == mOff + 1) begin
                            nValid = 1'b1; nY = satScale(int'(bus.x)); nCount = (mCount + 1) % 256;
                            nElapsed = 0; nMode = 2;
                        end
                    end
                end
                default: begin
                    if (!bus.enable) nMode = 0;
                    else begin
                        nElapsed = mElapsed + 1;
                        if (nElapsed >= mPer + mNudge) begin
                            nValid = 1'b1; nY = satScale(int'(bus.x)); nCount = (mCount + 1) % 256;
                            nElapsed = 0; nNudge = d;
                        end else begin
                            nNudge = nudged(mNudge, d);
                        end
                    end
                end
            endcase
            mMode <= nMode; mOff <= nOff; mPer <= nPer; mElapsed <= nElapsed;
            mNudge <= nNudge; mY <= nY; mCount <= nCount; mValid <= nValid;
        end
    end

    always @(negedge clk) begin
        checkOutput("y_valid", int'(bus.y_valid), int'(mValid));
        checkOutput("y", int'(bus.y), mY);
        checkOutput("samp_cnt", int'(bus.samp_cnt), mCount);
        checkOutput("busy", int'(bus.busy), (mMode != 0) ? 1 : 0);
        checkOutput("cfg_ready", int'(bus.cfg_ready), (mMode == 0) ? 1 : 0);
    end

    task automatic waitValid(input int limit, output int edgeIdx);
        edgeIdx = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.y_valid) begin
                edgeIdx = edgeNow();
                break;
            end
        end
        if (edgeIdx < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL capture timeout: got none, expected y_valid within %0d cycles", limit);
        end
    endtask

    task automatic expectCapture(input string name, input int spacing);
        int e;
        waitValid(80, e);
        checkOutput(name, e - lastEdge, spacing);
        lastEdge = e;
    endtask

    task automatic nudgePeriod(input string name, input int advCyc, input int retCyc, input int spacing);
        for (int i = 1; i <= 6; i++) begin
            bus.adv_req = (i == advCyc);
            bus.ret_req = (i == retCyc);
            @(negedge clk);
        end
        bus.adv_req = 1'b0;
        bus.ret_req = 1'b0;
        expectCapture(name, spacing);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst_n       = 1'b0;
        bus.adv_req = 1'b0;
        bus.ret_req = 1'b0;
        bus.x       = '0;
        applyStimulus(1'b0, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        checkOutput("reset y", int'(bus.y), 0);
        checkOutput("reset y_valid", int'(bus.y_valid), 0);
        checkOutput("reset busy", int'(bus.busy), 0);
        checkOutput("reset samp_cnt", int'(bus.samp_cnt), 0);
        checkOutput("reset cfg_ready", int'(bus.cfg_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Default offset 4 / period 32.
        bus.x = 16'sd100;
        applyStimulus(1'b1, 1'b0, 0, 0);
        lastEdge = edgeNow() + 1;
        expectCapture("default first", 5);
        checkOutput("default y", int'(bus.y), 800);
        checkOutput("default samp1", int'(bus.samp_cnt), 1);
        expectCapture("default second", 32);
        checkOutput("default samp2", int'(bus.samp_cnt), 2);
        expectCapture("default third", 32);
        checkOutput("default samp3", int'(bus.samp_cnt), 3);

        // Offset 0 / period 10.
        applyStimulus(1'b0, 1'b0, 0, 0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 0, 10);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 0, 10);
        lastEdge = edgeNow() + 1;
        expectCapture("off0 first", 1);
        checkOutput("off0 samp", int'(bus.samp_cnt), 4);
        expectCapture("per10", 10);
        applyStimulus(1'b1, 1'b1, 7, 20);
        checkOutput("run cfg_ready", int'(bus.cfg_ready), 0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 0, 0);
        expectCapture("per10 after cfg offer", 10);

        nudgePeriod("adv", 1, 0, 9);
        expectCapture("after adv", 10);
        nudgePeriod("ret", 0, 1, 11);
        expectCapture("after ret", 10);
        nudgePeriod("adv+ret same", 1, 1, 10);
        nudgePeriod("adv then ret", 1, 2, 10);

        bus.x = 16'sh1000;
        expectCapture("sat pos cap", 10);
        checkOutput("sat pos y", int'(bus.y), 32767);
        bus.x = -16'sh1001;
        expectCapture("sat neg cap", 10);
        checkOutput("sat neg y", int'(bus.y), -32768);
        bus.x = -16'sd3;
        expectCapture("small neg cap", 10);
        checkOutput("small neg y", int'(bus.y), -24);

        // Drop enable so it is sampled two edges before the due capture.
        repeat (7) @(negedge clk);
        bus.enable = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.y_valid) seen = 1'b1;
        end
        checkOutput("drop no capture", int'(seen), 0);
        checkOutput("drop y hold", int'(bus.y), -24);
        checkOutput("drop busy", int'(bus.busy), 0);

        // Reset mid-RUN.
        bus.enable = 1'b1;
        lastEdge = edgeNow() + 1;
        expectCapture("pre reset cap", 1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async rst y", int'(bus.y), 0);
        checkOutput("async rst samp", int'(bus.samp_cnt), 0);
        checkOutput("async rst busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        lastEdge = edgeNow() + 1;
        expectCapture("post reset first", 5);
        checkOutput("post reset samp", int'(bus.samp_cnt), 1);
        expectCapture("post reset period", 32);

        // Period 1 clamps to 2; an adv sampled on a capture edge gives one 1-clock gap.
        applyStimulus(1'b0, 1'b0, 0, 0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 0, 1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 0, 1);
        lastEdge = edgeNow() + 1;
        expectCapture("clamp first", 1);
        expectCapture("clamp period", 2);
        @(negedge clk);
        bus.adv_req = 1'b1;
        @(negedge clk);
        bus.adv_req = 1'b0;
        checkOutput("clamp cap k+2", int'(bus.y_valid), 1);
        @(negedge clk);
        checkOutput("clamp cap k+3", int'(bus.y_valid), 1);
        @(negedge clk);
        checkOutput("clamp gap k+4", int'(bus.y_valid), 0);
        @(negedge clk);
        checkOutput("clamp cap k+5", int'(bus.y_valid), 1);

        // Long run at period 2 carries samp_cnt through its 255->0 wrap.
        repeat (600) @(negedge clk);
        bus.enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ds_strobe_sched.md
Name: ds_strobe_sched

Overview:
- Scheduler for the FSK demodulator's decimation stage.
- Waits for a programmable initial phase offset, then captures one scaled input sample every symbol period and emits it with a valid pulse.
- Accepts one-clock advance/retard nudges from the timing-recovery loop, and accepts offset/period reconfiguration through a handshake while idle.
- Sits between the matched-filter output and the symbol decision logic.

Parameters:
- DW, 16, input/output sample width (signed).
- CNT_W, 6, phase-counter width.
- DEF_OFFSET, 4, initial offset loaded at reset.
- DEF_PERIOD, 32, symbol period in clocks loaded at reset.
- GAIN_SHIFT, 3, left-shift gain applied to captured samples.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run request; low forces IDLE.
- cfg_valid  in  1  configuration offer.
- cfg_ready  out  1  high only in IDLE.
- cfg_offset  in  CNT_W  new initial offset.
- cfg_period  in  CNT_W  new symbol period.
- adv_req  in  1  shorten the current period by one clock.
- ret_req  in  1  lengthen the current period by one clock.
- x  in  DW  signed input sample stream.
- y  out  DW  signed captured, scaled sample.
- y_valid  out  1  one-cycle pulse per capture.
- busy  out  1  high in ALIGN or RUN.
- samp_cnt  out  8  capture count, wraps 255->0.

Behaviour:
- Reset (asynchronous, active-low):
  - Outputs: state=IDLE, cnt=0, y=0, y_valid=0, busy=0, samp_cnt=0, cfg_ready=1.
  - Config and flags: off_r=DEF_OFFSET, per_r=DEF_PERIOD, adv/ret pending flags=0.
  - Reset asserted mid-operation takes effect immediately, with no partial capture.
- States: IDLE, ALIGN, RUN (2-bit encoding).
- IDLE:
  - cfg_ready=1.
  - cfg_valid&cfg_ready at an edge latches off_r=cfg_offset and per_r=max(cfg_period,2).
  - enable high at edge E0 -> ALIGN with cnt=0 and pending flags cleared.
  - If cfg_valid and enable are both high at the same edge, the new config is latched and used in ALIGN.
- ALIGN:
  - cnt increments each clock.
  - At the edge where cnt==off_r: capture, cnt<=0, go to RUN.
  - First y_valid is therefore high in the cycle after edge E0+off_r+1; off_r=0 gives one cycle of latency.
- RUN:
  - cnt increments each clock.
  - Terminal value is per_r-1 nominal, per_r-2 if adv is pending, per_r if ret is pending.
  - At terminal: capture, cnt<=0, pending flags cleared.
  - Capture spacing is therefore per_r, per_r-1 or per_r+1 clocks.
- Capture:
  - y <= sat(x <<< GAIN_SHIFT), saturated to +(2^(DW-1)-1) / -(2^(DW-1)) rather than wrapped.
  - y_valid=1 for exactly one cycle; samp_cnt increments.
  - y holds its value between captures.
- Nudge rules (ALIGN and RUN):
  - adv_req and ret_req high in the same cycle: both ignored.
  - adv_req while ret is pending (or the reverse): cancels the pending flag, net zero.
  - A repeated same-direction request while pending: ignored. At most one nudge per period.
  - A request in the same cycle as a capture edge applies to the next period.
  - Requests in ALIGN apply to the first RUN period.
  - Requests in IDLE: ignored.
- enable low in ALIGN or RUN -> IDLE at the next edge.
  - y_valid=0; y and samp_cnt hold; no capture on that edge.
- Configuration:
  - cfg_ready=0 outside IDLE; cfg_valid is ignored there.
  - per_r is clamped to [2, 2^CNT_W-1]; cnt always fits in CNT_W bits.
- busy=1 in ALIGN and RUN.

Decomposition:
- Package fsk_ds_pkg holds:
  - state enum (IDLE/ALIGN/RUN);
  - DEF_OFFSET, DEF_PERIOD, GAIN_SHIFT;
  - the saturation limits MAX_POS/MAX_NEG derived from DW.
- One sub-module, ds_sat_shift: combinational saturating arithmetic left shift (DW, GAIN_SHIFT).
- FSM, counter and nudge logic stay in the top module.

Test Plan:
- Reset defaults, enable rises at edge 0, x=100 constant -> y_valid at edges 5, 37, 69; y=800; samp_cnt 1,2,3.
- cfg_offset=0, cfg_period=10 with cfg_valid in IDLE, then enable -> first capture one cycle after enable; captures every 10 clocks. A config offer during RUN sees cfg_ready=0 and is unchanged.
- Period 10 in RUN:
  - single adv_req -> spacing 9 then 10;
  - single ret_req -> 11 then 10;
  - adv+ret in the same cycle -> 10;
  - adv then ret in the same period -> 10.
- x=16'sh1000 -> y=16'sh7FFF; x=-16'sh1001 -> y=16'sh8000; x=-3 -> y=-24.
- enable dropped two clocks before a capture -> no y_valid, IDLE next edge, y holds. Reset pulsed mid-RUN -> y=0 and samp_cnt=0 immediately; config returns to 4/32.
- cfg_period=1 -> clamped to 2; captures every 2 clocks; adv_req gives a 1-clock spacing once.
